// File: rtl/display_scanner_if.sv
// display_scanner_if: value/load in, decoder nibble and digit enables out
interface display_scanner_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] value_in;
  logic                load;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   digit_en_n;
  logic                pending;
  logic                frame_done;
  modport master (output value_in, load, input nibble, digit_en_n, pending, frame_done);
  modport slave  (input value_in, load, output nibble, digit_en_n, pending, frame_done);
endinterface

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed hex digit scanner with blanking gaps and frame-aligned updates
// Optional leading-zero blanking when DISPLAY_LZ_BLANK_EN is defined.
module display_scanner #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  display_scanner_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int MX = DIV > GAP ? DIV : GAP;
  localparam int PW = $clog2(MX + 1);
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;
  state_t              state_q;
  logic [4*DIGITS-1:0] disp_q, shad_q, disp_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       cnt_q;
  logic [3:0]          nib_q, nib_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                pend_q, fd_q, wrap, show_end, gap_end, lz;
  // Next-slot values are only consumed on IDLE exit or a gap end, so the
  // displayed value can only change there.
  always_comb begin
    show_end = cnt_q == PW'(DIV - 1);
    gap_end  = cnt_q == PW'(GAP - 1);
    wrap     = state_q == S_GAP && gap_end && idx_q == IW'(DIGITS - 1);
    idx_d    = (state_q == S_IDLE || wrap) ? '0 : idx_q + IW'(1);
    disp_d   = ((state_q == S_IDLE || wrap) && bus.load) ? bus.value_in :
               (wrap && pend_q) ? shad_q : disp_q;
    nib_d    = 4'(disp_d >> (4 * idx_d));
`ifdef DISPLAY_LZ_BLANK_EN
    lz       = idx_d != '0 && (disp_d >> (4 * idx_d)) == '0;
`else
    lz       = 1'b0;
`endif
    en_d     = lz ? '1 : ~(DIGITS'(1) << idx_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      disp_q  <= '0;
      shad_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      nib_q   <= '0;
      en_q    <= '1;
      pend_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= wrap;
      if (state_q == S_IDLE) begin
        if (bus.load) begin
          state_q <= S_SHOW;
          disp_q  <= disp_d;
          idx_q   <= idx_d;
          cnt_q   <= '0;
          nib_q   <= nib_d;
          en_q    <= en_d;
        end
      end else if (state_q == S_SHOW) begin
        cnt_q <= show_end ? '0 : cnt_q + PW'(1);
        if (show_end) begin
          state_q <= S_GAP;
          en_q    <= '1;
        end
      end else begin
        cnt_q <= gap_end ? '0 : cnt_q + PW'(1);
        if (gap_end) begin
          state_q <= S_SHOW;
          disp_q  <= disp_d;
          idx_q   <= idx_d;
          nib_q   <= nib_d;
          en_q    <= en_d;
        end
      end
      // A load landing on the wrap edge goes straight to the display instead.
      if (state_q != S_IDLE && bus.load && !wrap) begin
        shad_q <= bus.value_in;
        pend_q <= 1'b1;
      end else if (wrap) begin
        pend_q <= 1'b0;
      end
    end
  end
  assign bus.nibble     = nib_q;
  assign bus.digit_en_n = en_q;
  assign bus.pending    = pend_q;
  assign bus.frame_done = fd_q;
endmodule
